// File: rtl/packer_pkg.sv
// Shared defaults and types for the FIFO byte packer and its output slot.
// Optional partial-word flush is enabled with the PACKER_FLUSH_EN macro.
package packer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;
    localparam int LANE_W    = $clog2(DEF_LANES);

    typedef logic [LANE_W:0] cnt_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/fifo_pack_out_slot.sv
// One-entry valid/ready holding register for packed words (data plus optional keep).
// The payload only changes on load, so it is stable while the consumer stalls.
module fifo_pack_out_slot
    import packer_pkg::*;
#(
    parameter int PW = 32
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] in_word,
    input  logic          o_ready,
    output logic          o_valid,
    output logic [PW-1:0] o_word
);

    slot_state_t   state_r;
    slot_state_t   state_s;
    logic [PW-1:0] word_r;

    // slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // a load in the same cycle as a handshake keeps the slot full with the new word
    always_comb begin
        state_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load) state_s = SLOT_FULL;
                else      state_s = SLOT_EMPTY;
            end
            SLOT_FULL: begin
                if (load || !o_ready) state_s = SLOT_FULL;
                else                  state_s = SLOT_EMPTY;
            end
            default: state_s = SLOT_EMPTY;
        endcase
    end

    // payload register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= {PW{1'b0}};
        end else if (load) begin
            word_r <= in_word;
        end
    end

    // output decode
    always_comb begin
        o_valid = (state_r == SLOT_FULL);
        o_word  = word_r;
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains a byte FIFO and packs LANES bytes little-endian into words on a valid/ready stream.
// Define PACKER_FLUSH_EN to add the flush input and o_keep byte mask for partial words.
module fifo_byte_packer
    import packer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_dout,
    output logic                   fifo_rd_en,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [WIDTH*LANES-1:0] o_data
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                   flush,
    output logic [LANES-1:0]       o_keep
`endif
);

    localparam int             LW       = $clog2(LANES);
    localparam int             CW       = LW + 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(LANES);
`ifdef PACKER_FLUSH_EN
    localparam int             PW       = WIDTH*LANES + LANES;
`else
    localparam int             PW       = WIDTH*LANES;
`endif

    logic [CW-1:0]          cnt_r;
    logic                   pend_r;
    logic [WIDTH-1:0]       lane_r [LANES];
    logic                   slot_free_s;
    logic                   xfer_s;
    logic [CW-1:0]          base_s;
    logic                   room_s;
    logic [WIDTH*LANES-1:0] asm_word_s;
    logic [PW-1:0]          slot_in_s;
    logic [PW-1:0]          slot_out_s;
`ifdef PACKER_FLUSH_EN
    logic                   flush_req_r;
    logic [LANES-1:0]       keep_s;
`endif

    // transfer decision and pop request; the pop budget counts the byte still in flight
    always_comb begin
        slot_free_s = !o_valid || o_ready;
`ifdef PACKER_FLUSH_EN
        xfer_s = slot_free_s && ((cnt_r == CNT_FULL) ||
                 (flush_req_r && !pend_r && (cnt_r != {CW{1'b0}})));
`else
        xfer_s = slot_free_s && (cnt_r == CNT_FULL);
`endif
        if (xfer_s) base_s = {CW{1'b0}};
        else        base_s = cnt_r;
        room_s = ({1'b0, base_s} + {{CW{1'b0}}, pend_r}) < {1'b0, CNT_FULL};
`ifdef PACKER_FLUSH_EN
        fifo_rd_en = !rst && !fifo_empty && room_s && !flush_req_r;
`else
        fifo_rd_en = !rst && !fifo_empty && room_s;
`endif
    end

    // lane capture, byte count and in-flight pop tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            pend_r <= 1'b0;
            for (int i = 0; i < LANES; i++) lane_r[i] <= {WIDTH{1'b0}};
        end else begin
            pend_r <= fifo_rd_en;
            if (pend_r) begin
                lane_r[base_s[LW-1:0]] <= fifo_dout;
                cnt_r <= base_s + CW'(1);
            end else begin
                cnt_r <= base_s;
            end
        end
    end

`ifdef PACKER_FLUSH_EN
    // flush request holds until the partial word has moved to the output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_req_r <= 1'b0;
        end else begin
            flush_req_r <= (flush_req_r || (flush && ((cnt_r != {CW{1'b0}}) || pend_r)))
                           && !(xfer_s && !pend_r);
        end
    end
`endif

    // assemble the outgoing word; lanes at or above cnt read as zero
    always_comb begin
        asm_word_s = {(WIDTH*LANES){1'b0}};
`ifdef PACKER_FLUSH_EN
        keep_s = {LANES{1'b0}};
`endif
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < cnt_r) begin
                asm_word_s[i*WIDTH +: WIDTH] = lane_r[i];
`ifdef PACKER_FLUSH_EN
                keep_s[i] = 1'b1;
`endif
            end else begin
                asm_word_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end
        end
    end

`ifdef PACKER_FLUSH_EN
    assign slot_in_s        = {keep_s, asm_word_s};
    assign {o_keep, o_data} = slot_out_s;
`else
    assign slot_in_s = asm_word_s;
    assign o_data    = slot_out_s;
`endif

    fifo_pack_out_slot #(
        .PW(PW)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (xfer_s),
        .in_word (slot_in_s),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_word  (slot_out_s)
    );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Randomized bench for fifo_byte_packer: a byte FIFO model feeds the DUT, popped bytes are grouped
// into expected words by a queue model, and one compare process checks every accepted word.
module tb_fifo_byte_packer;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DW    = WIDTH*LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             o_valid;
    logic             o_ready;
    logic [DW-1:0]    o_data;
    logic             flush_b;
`ifdef PACKER_FLUSH_EN
    logic [LANES-1:0] o_keep;
`endif

    always #5 clk = ~clk;

    fifo_byte_packer dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data)
`ifdef PACKER_FLUSH_EN
        ,
        .flush      (flush_b),
        .o_keep     (o_keep)
`endif
    );

    int               n_vec = 0;
    int               n_err = 0;
    int               n_acc = 0;
    int               cyc = 0;
    int               last_cyc = 0;
    int               prev_cyc = 0;
    logic [7:0]       fq [$];
    logic [7:0]       acc [$];
    logic [DW-1:0]    exp_d [$];
    logic [LANES-1:0] exp_k [$];
    logic [DW-1:0]    last_d = '0;
    logic [LANES-1:0] last_k = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: popped bytes in order, LANES per word, partial word on an effective flush
    function automatic void emit();
        logic [DW-1:0]    w = '0;
        logic [LANES-1:0] k = '0;
        for (int i = 0; i < acc.size(); i++) begin
            w[i*WIDTH +: WIDTH] = acc[i];
            k[i] = 1'b1;
        end
        exp_d.push_back(w);
        exp_k.push_back(k);
        acc.delete();
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // one clock: sample the pop away from the edge, then update FIFO model and reference
    task automatic tick(input logic nxt_flush);
        logic popped;
        logic take;
        @(negedge clk);
        popped = fifo_rd_en && !fifo_empty && !rst;
        @(posedge clk);
        #1;
        take = flush_b && (acc.size() > 0);
        if (popped) begin
            fifo_dout = fq.pop_front();
            acc.push_back(fifo_dout);
        end
        if (acc.size() == LANES || take) emit();
        fifo_empty = (fq.size() == 0);
        flush_b = nxt_flush;
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (n_acc < target && n < budget) begin
            tick(1'b0);
            n++;
        end
        if (n_acc < target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_words: got %0d words, expected %0d within %0d cycles", n_acc, target, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fq.delete();
        acc.delete();
        exp_d.delete();
        exp_k.delete();
        flush_b = 1'b0;
        fifo_empty = 1'b0;
        @(negedge clk);
        check("rst_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        check("rst_valid", 64'(o_valid), 64'(1'b0));
        check("rst_data", 64'(o_data), 64'(0));
`ifdef PACKER_FLUSH_EN
        check("rst_keep", 64'(o_keep), 64'(0));
`endif
        @(posedge clk);
        #1;
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // compare process: every accepted word against the model, and hold-stability under stall
    always @(negedge clk) begin : cmp
        logic             prev_stall;
        logic [DW-1:0]    prev_d;
        logic [LANES-1:0] prev_k;
        logic [LANES-1:0] cur_k;
        logic [DW-1:0]    ed;
        logic [LANES-1:0] ek;
        cyc++;
`ifdef PACKER_FLUSH_EN
        cur_k = o_keep;
`else
        cur_k = '1;
`endif
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(o_valid), 64'(1'b1));
                check("hold_data", 64'(o_data), 64'(prev_d));
`ifdef PACKER_FLUSH_EN
                check("hold_keep", 64'(cur_k), 64'(prev_k));
`endif
            end
            if (o_valid && o_ready) begin
                if (exp_d.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_word: got %0h, expected no word", o_data);
                end else begin
                    ed = exp_d.pop_front();
                    ek = exp_k.pop_front();
                    check("word", 64'(o_data), 64'(ed));
`ifdef PACKER_FLUSH_EN
                    check("keep", 64'(cur_k), 64'(ek));
`endif
                end
                last_d = o_data;
                last_k = cur_k;
                prev_cyc = last_cyc;
                last_cyc = cyc;
                n_acc++;
            end
            prev_stall = o_valid && !o_ready;
            prev_d = o_data;
            prev_k = cur_k;
        end
    end

    initial begin
        int base;
        int n;
        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        o_ready = 1'b0;
        flush_b = 1'b0;
        do_reset();

        // single word, little-endian
        o_ready = 1'b1;
        base = n_acc;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(base + 1, 40);
        check("t1_word", 64'(last_d), 64'h44332211);
        check("t1_keep", 64'(last_k), 64'hF);
        repeat (10) tick(1'b0);
        check("t1_single", 64'(n_acc), 64'(base + 1));

        // streaming throughput
        base = n_acc;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_words(base + 2, 60);
        check("t2_word2", 64'(last_d), 64'h08070605);
        check("t2_gap", 64'(last_cyc - prev_cyc <= 5), 64'(1'b1));

        // back-pressure: no pops once assembly and slot are both full
        base = n_acc;
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        wait_words(base + 1, 40);
        check("t3_word1", 64'(last_d), 64'h33323130);
        o_ready = 1'b0;
        repeat (25) tick(1'b0);
        check("t3_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        check("t3_fifo_left", 64'(fq.size()), 64'(4));
        check("t3_valid", 64'(o_valid), 64'(1'b1));
        check("t3_held", 64'(o_data), 64'h37363534);
        o_ready = 1'b1;
        wait_words(base + 4, 80);
        check("t3_last", 64'(last_d), 64'h3f3e3d3c);

`ifdef PACKER_FLUSH_EN
        // partial word flush, then an ignored flush with nothing buffered
        base = n_acc;
        push(8'hAA); push(8'hBB);
        repeat (6) tick(1'b0);
        tick(1'b1);
        wait_words(base + 1, 20);
        check("t4_word", 64'(last_d), 64'h0000BBAA);
        check("t4_keep", 64'(last_k), 64'h3);
        repeat (3) tick(1'b0);
        tick(1'b1);
        repeat (10) tick(1'b0);
        check("t4_no_word", 64'(n_acc), 64'(base + 1));

        // flush while a pop is still in flight
        base = n_acc;
        push(8'hDD); push(8'hEE);
        repeat (6) tick(1'b0);
        push(8'hCC);
        tick(1'b1);
        wait_words(base + 1, 20);
        check("t6_word", 64'(last_d), 64'h00CCEEDD);
        check("t6_keep", 64'(last_k), 64'h7);
`endif

        // reset in the middle of a word
        push(8'hE1); push(8'hE2);
        repeat (5) tick(1'b0);
        do_reset();
        base = n_acc;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_words(base + 1, 30);
        check("t5_word", 64'(last_d), 64'h88776655);
        repeat (10) tick(1'b0);
        check("t5_single", 64'(n_acc), 64'(base + 1));

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            o_ready = ($urandom_range(0, 3) != 0);
            if (fq.size() < 16 && $urandom_range(0, 9) < 6) push(8'($urandom));
`ifdef PACKER_FLUSH_EN
            tick($urandom_range(0, 39) == 0);
`else
            tick(1'b0);
`endif
        end

        // drain everything that forms whole or flushed words
        o_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
        repeat (30) tick(1'b0);
        tick(1'b1);
`endif
        n = 0;
        while ((exp_d.size() > 0 || fq.size() > 0) && n < 400) begin
            tick(1'b0);
            n++;
        end
        repeat (5) tick(1'b0);
        check("drain_expected", 64'(exp_d.size()), 64'(0));
        check("drain_fifo", 64'(fq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
